// File: rtl/psc_trigger.sv
`default_nettype none
// ============================================================================
//  Module      : psc_trigger
//  Description : Converts an asynchronous active-low event-receiver trigger
//                into one framed serial message for a power-supply
//                controller. It also produces a free-running clk/CLK_DIV
//                reference clock.
//
//                Frame: start bit (0), FRAME_BYTE sent LSB first, optional
//                even-parity bit, stop bit (1). Each bit lasts CLK_DIV cycles.
//
//  Parameters  : CLK_DIV      - clk cycles per serial bit and per
//                               clk_10_logic period (even, >= 4)
//                FRAME_BYTE   - payload byte of every frame
//  Macro       : PSC_TRIGGER_PARITY_EN - when defined, an even-parity bit
//                follows the data bits (11-bit frame instead of 10)
//
//  Ports       : clk          - system clock, rising edge
//                reset        - synchronous, active-high
//                evr_trigger  - asynchronous trigger, active low, idle high
//                psc_output   - serial TX line, idle high
//                trigger_out  - high while a frame is on the line
//                clk_10_logic - clk / CLK_DIV, 50% duty cycle
//
//  Revision    : 1.0 - initial release
// ============================================================================
module psc_trigger #(
   parameter int         CLK_DIV    = 10,
   parameter logic [7:0] FRAME_BYTE = 8'hA5
) (
   input  logic clk,
   input  logic reset,
   input  logic evr_trigger,
   output logic psc_output,
   output logic trigger_out,
   output logic clk_10_logic
);

   localparam int             CNT_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);

`ifdef PSC_TRIGGER_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd4
   } state_t;
`endif

   // -------------------------------------------------------------------------
   // Trigger synchronizer and falling-edge detector. All flops reset to 0, so
   // a trigger line held low through reset release looks like "already low"
   // and cannot fire until it has gone high and then low again.
   // -------------------------------------------------------------------------
   logic sync_meta;
   logic sync_stable;
   logic sync_dly;
   logic trig_event;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta   <= 1'b0;
         sync_stable <= 1'b0;
         sync_dly    <= 1'b0;
      end else begin
         sync_meta   <= evr_trigger;
         sync_stable <= sync_meta;
         sync_dly    <= sync_stable;
      end
   end

   assign trig_event = sync_dly & ~sync_stable;

   // -------------------------------------------------------------------------
   // Free-running reference clock. The output is registered from the count,
   // so the first high level appears on the first edge after reset release.
   // -------------------------------------------------------------------------
   logic [CNT_W-1:0] div_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt      <= '0;
         clk_10_logic <= 1'b0;
      end else begin
         clk_10_logic <= (div_cnt < CNT_HALF);
         div_cnt      <= (div_cnt == CNT_LAST) ? '0 : div_cnt + 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Frame state machine
   // -------------------------------------------------------------------------
   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] bit_cnt;     // cycles spent in the current bit
   logic [2:0]       data_idx;    // index of the data bit being sent
   logic             bit_end;
   logic             tx_bit;

   assign bit_end = (bit_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      tx_bit     = 1'b1;
      case (state)
         IDLE: begin
            // Edges seen in any other state are dropped, never queued.
            if (trig_event) begin
               next_state = START;
            end
         end
         START: begin
            tx_bit = 1'b0;
            if (bit_end) begin
               next_state = DATA;
            end
         end
         DATA: begin
            tx_bit = FRAME_BYTE[data_idx];
            if (bit_end && (data_idx == 3'd7)) begin
`ifdef PSC_TRIGGER_PARITY_EN
               next_state = PARITY;
`else
               next_state = STOP;
`endif
            end
         end
`ifdef PSC_TRIGGER_PARITY_EN
         PARITY: begin
            tx_bit = ^FRAME_BYTE;
            if (bit_end) begin
               next_state = STOP;
            end
         end
`endif
         STOP: begin
            tx_bit = 1'b1;
            if (bit_end) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Bit timing restarts at every frame and ignores the reference clock phase.
   // The line outputs are registered from the state, which places the start
   // bit one edge after the FSM leaves IDLE. trigger_out therefore spans
   // exactly the frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt     <= '0;
         data_idx    <= 3'd0;
         psc_output  <= 1'b1;
         trigger_out <= 1'b0;
      end else begin
         if ((state == IDLE) || bit_end) begin
            bit_cnt <= '0;
         end else begin
            bit_cnt <= bit_cnt + 1'b1;
         end

         if (state == IDLE) begin
            data_idx <= 3'd0;
         end else if ((state == DATA) && bit_end) begin
            data_idx <= data_idx + 3'd1;
         end

         psc_output  <= tx_bit;
         trigger_out <= (state != IDLE);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_psc_trigger.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_psc_trigger
//  Description : Self-checking bench for psc_trigger. It uses a table of
//                reset and reference-clock vectors and a start-time
//                scoreboard. It also applies hand-written trigger sequences
//                that cover the multi-cycle corner cases.
//  Macro       : PSC_TRIGGER_PARITY_EN - selects the 11-bit frame expectation
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psc_trigger;

   localparam int         CLK_DIV    = 10;
   localparam logic [7:0] FRAME_BYTE = 8'hA5;
`ifdef PSC_TRIGGER_PARITY_EN
   localparam int         FRAME_BITS = 11;
`else
   localparam int         FRAME_BITS = 10;
`endif
   localparam int         FRAME_CYC  = FRAME_BITS * CLK_DIV;

   logic clk         = 1'b0;
   logic reset       = 1'b1;
   logic evr_trigger = 1'b1;
   logic psc_output;
   logic trigger_out;
   logic clk_10_logic;

   always #5 clk = ~clk;

   psc_trigger #(
      .CLK_DIV    (CLK_DIV),
      .FRAME_BYTE (FRAME_BYTE)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .evr_trigger  (evr_trigger),
      .psc_output   (psc_output),
      .trigger_out  (trigger_out),
      .clk_10_logic (clk_10_logic)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int edge_n   = 0;
   int n_pushed = 0;
   int exp_start_q[$];

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edge_n);
      end
   endtask

   // Expected serial bit at position idx of a frame.
   function automatic logic frame_bit(input int idx);
      logic [7:0] b;
      b = FRAME_BYTE;
      if (idx == 0)      return 1'b0;
      else if (idx <= 8) return b[idx-1];
`ifdef PSC_TRIGGER_PARITY_EN
      else if (idx == 9) return ^b;
`endif
      else               return 1'b1;
   endfunction

   // ------------------------------------------------------------------------
   // Output monitor: consumes the start-time scoreboard and checks each bit
   // in mid-bit, plus frame width and idle level.
   // ------------------------------------------------------------------------
   bit   in_frame    = 1'b0;
   int   start_cyc   = 0;
   int   frames_seen = 0;
   int   mon_off;
   int   exp_start;
   logic prev_trig   = 1'b0;

   always @(posedge clk) begin
      #1;
      if (reset === 1'b1) begin
         in_frame  = 1'b0;
         prev_trig = 1'b0;
      end else begin
         if ((trigger_out === 1'b1) && (prev_trig !== 1'b1)) begin
            frames_seen++;
            in_frame  = 1'b1;
            start_cyc = edge_n;
            if (exp_start_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_frame: frame started at edge %0d, none expected", edge_n);
            end else begin
               exp_start = exp_start_q.pop_front();
               check("start_cycle", edge_n, exp_start);
            end
         end else if (in_frame && (trigger_out !== 1'b1)) begin
            check("frame_width", edge_n - start_cyc, FRAME_CYC);
            check("idle_after_frame", {31'd0, psc_output}, 32'd1);
            in_frame = 1'b0;
         end else if (in_frame) begin
            mon_off = edge_n - start_cyc;
            if (((mon_off % CLK_DIV) == CLK_DIV/2) && ((mon_off / CLK_DIV) < FRAME_BITS)) begin
               check($sformatf("frame_bit%0d", mon_off / CLK_DIV),
                     {31'd0, psc_output}, {31'd0, frame_bit(mon_off / CLK_DIV)});
            end
         end
         prev_trig = trigger_out;
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers (all called at a falling clock edge)
   // ------------------------------------------------------------------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Falling trigger edge that must be accepted: the start bit is due on the
   // 3rd edge after the first sampling edge (edge_n + 1).
   task automatic drive_low_expect();
      evr_trigger = 1'b0;
      exp_start_q.push_back(edge_n + 4);
      n_pushed++;
   endtask

   task automatic wait_start();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_frame) return;
      end
      n_checks++;
      n_fail++;
      $display("FAIL wait_start: no frame within 20 cycles, got none, expected one");
   endtask

   task automatic wait_offset(input int off);
      for (int i = 0; i < FRAME_CYC + 20; i++) begin
         if (edge_n >= start_cyc + off) return;
         @(negedge clk);
      end
      n_checks++;
      n_fail++;
      $display("FAIL wait_offset: edge %0d, expected to reach %0d", edge_n, start_cyc + off);
   endtask

   typedef struct {
      logic rst;
      logic evr;
      logic psc;
      logic trig;
      logic clk10;
   } vec_t;

   vec_t vecs[17];
   int   t0;

   initial begin
      // Reset for 5 cycles, then the reference clock runs 5 high / 5 low.
      for (int i = 0; i < 17; i++) begin
         vecs[i].rst   = (i < 5);
         vecs[i].evr   = 1'b1;
         vecs[i].psc   = 1'b1;
         vecs[i].trig  = 1'b0;
         vecs[i].clk10 = (i >= 5) && (((i - 5) % 10) < 5);
      end

      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         reset       = vecs[i].rst;
         evr_trigger = vecs[i].evr;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_psc", i),   {31'd0, psc_output},   {31'd0, vecs[i].psc});
         check($sformatf("vec%0d_trig", i),  {31'd0, trigger_out},  {31'd0, vecs[i].trig});
         check($sformatf("vec%0d_clk10", i), {31'd0, clk_10_logic}, {31'd0, vecs[i].clk10});
      end

      // Single long low pulse: one frame, no retrigger while held low.
      @(negedge clk);
      drive_low_expect();
      tick(600);
      evr_trigger = 1'b1;
      tick(20);

      // Two pulses 13500 cycles apart give two identical frames.
      t0 = edge_n;
      drive_low_expect();
      tick(600);
      evr_trigger = 1'b1;
      tick(13500 - 600);
      drive_low_expect();
      tick(600);
      evr_trigger = 1'b1;
      tick(20);

      // Second falling edge 40 cycles into a frame is ignored.
      drive_low_expect();
      wait_start();
      evr_trigger = 1'b1;
      wait_offset(40);
      evr_trigger = 1'b0;
      tick(20);
      evr_trigger = 1'b1;
      tick(FRAME_CYC + 10);

      // Edge detected during the last stop-bit cycle is ignored.
      drive_low_expect();
      wait_start();
      tick(5);
      evr_trigger = 1'b1;
      wait_offset(FRAME_CYC - 4);
      evr_trigger = 1'b0;
      tick(30);
      evr_trigger = 1'b1;
      tick(10);

      // Edge detected on the first IDLE cycle starts a back-to-back frame.
      drive_low_expect();
      wait_start();
      tick(5);
      evr_trigger = 1'b1;
      wait_offset(FRAME_CYC - 3);
      drive_low_expect();
      tick(FRAME_CYC + 20);
      evr_trigger = 1'b1;
      tick(10);

      // Reset 50 cycles into a frame aborts it with no resumption.
      drive_low_expect();
      wait_start();
      wait_offset(50);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_psc",  {31'd0, psc_output},  32'd1);
      check("abort_trig", {31'd0, trigger_out}, 32'd0);
      tick(5);
      reset = 1'b0;
      tick(300);
      evr_trigger = 1'b1;
      tick(5);
      drive_low_expect();
      tick(FRAME_CYC + 20);
      evr_trigger = 1'b1;
      tick(10);

      check("queue_empty", exp_start_q.size(), 0);
      check("frame_count", frames_seen, n_pushed);
      check("frame_closed", {31'd0, in_frame}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
